tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Receive-side counterpart of the mux path: splits a time-division-multiplexed word stream
//  back into NCH parallel channels. Locks to a start-of-frame marker, steers each word to its
//  channel slot, and presents a complete frame with a valid/ready handshake. Sits between the
//  serial TDM link and the per-channel consumers.
// PARAMETERS
//  WIDTH  8  bits per channel word
//  NCH    4  channels per frame (>=2); CW = $clog2(NCH) is a derived localparam
// PORTS
//  clk        in   1          single clock, rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  in_valid   in   1          in_data/in_sof qualify this cycle; no upstream backpressure
//  in_data    in   WIDTH      TDM word
//  in_sof     in   1          marks the channel-0 word of a frame
//  out_ready  in   1          consumer accepts out_data this cycle
//  out_data   out  NCH*WIDTH  frame; channel k at [k*WIDTH +: WIDTH]
//  out_valid  out  1          frame held on out_data
//  frame_err  out  1          1-cycle pulse on framing violation
//  overflow   out  1          1-cycle pulse when an unaccepted frame is overwritten
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=HUNT, ch=0, out_data=0, out_valid=0,
//    frame_err=0, overflow=0, collect buffer=0.
//  - Words accepted only when in_valid=1; in_valid=0 holds state and ch unchanged.
//  - HUNT: words discarded until in_valid&in_sof; that word -> slot 0, ch=1, go COLLECT.
//  - COLLECT: word written to slot ch, ch++.
//    * in_sof=1 with ch!=0: frame_err pulse; partial frame dropped; word taken as slot 0, ch=1.
//    * in_sof=0 with ch==0: frame_err pulse; word discarded; go HUNT.
//    * word at ch==NCH-1: ch wraps to 0; full frame (buffer + this word) loads out_data on the
//      same edge; out_valid=1 from the next cycle. Latency: last word edge -> out_valid 1 clk.
//  - Handshake: out_valid&out_ready clears out_valid next cycle; out_data holds until
//    accepted or replaced.
//  - Frame completion with out_valid=1 and out_ready=0: out_data overwritten, out_valid stays
//    1, overflow pulse.
//  - Completion same cycle as out_valid&out_ready: new frame loads, out_valid stays 1,
//    no overflow.
//  - Collect buffer separate from out_data: collection continues during backpressure.
//  - Reset mid-frame: partial frame and pending output discarded; relock requires in_sof.
//  - NCH=2: ch is 1 bit; same rules.
// STRUCTURE
//  - tdm_defs.vh (shared include): state encodings ST_HUNT/ST_COLLECT, default WIDTH/NCH.
//  - Sub-module tdm_chan_cnt: modulo-NCH counter with load-to-1, clear, enable,
//    and last (ch==NCH-1) flag.
//  - Top: 2-state FSM, collect buffer, output register, handshake and pulse logic.
// TESTING (WIDTH=8, NCH=4)
//  1 Reset, then sof+A1,B2,C3,D4 on 4 consecutive cycles, out_ready=1 -> out_valid high for
//    one cycle, out_data=32'hD4C3B2A1, no err.
//  2 Words 11,22 without sof after reset -> discarded, out_valid stays 0; then sof frame
//    locks normally.
//  3 sof+01,02, then sof+10,20,30,40 -> frame_err pulse once; out_data=32'h40302010.
//  4 out_ready=0, two back-to-back frames -> overflow pulse at 2nd completion; out_data=2nd
//    frame; out_valid stays 1.
//  5 in_valid gaps (1-0-1-0...) inside a frame -> same out_data as gap-free frame;
//    assert reset_n low mid-frame -> all outputs 0 immediately.
//  6 Frame completes in the cycle out_valid&out_ready -> out_valid never drops,
//    no overflow, new data shown.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Package: tdm_demux_pkg
// Shared definitions for the TDM receive path: FSM state encoding and
// default frame geometry used by tdm_demux and its channel counter.
package tdm_demux_pkg;

  // HUNT: waiting for a start-of-frame marker; COLLECT: locked to frames.
  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } tdm_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

endpackage

// File: rtl/tdm_demux_chan_cnt.sv
// Module: tdm_demux_chan_cnt
// Modulo-NCH channel slot counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : force slot to 0 (highest priority)
//   load1        : force slot to 1 (a start-of-frame word went to slot 0)
//   en           : advance one slot, wrapping NCH-1 -> 0
//   ch           : current slot
//   last         : ch == NCH-1
module tdm_demux_chan_cnt #(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          load1,
  input  logic          en,
  output logic [CW-1:0] ch,
  output logic          last
);

  assign last = (ch == CW'(NCH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch <= '0;
    end else if (clear) begin
      ch <= '0;
    end else if (load1) begin
      ch <= CW'(1);
    end else if (en) begin
      ch <= last ? '0 : ch + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Module: tdm_demux
// Splits a TDM word stream into NCH parallel channels. Locks on in_sof,
// steers each word to its slot in a collect buffer, and on the last slot
// publishes the whole frame to out_data with a valid/ready handshake.
//
// Handshake: out_valid is high while a frame is held on out_data; a frame
// is consumed on a cycle where out_valid && out_ready. out_data is stable
// until consumed or replaced by a newer frame (replacement of an unconsumed
// frame raises overflow). in_valid has no backpressure.
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   in_valid/in_data/in_sof : TDM word input, in_sof marks channel 0
//   out_ready          : consumer accepts the held frame
//   out_data           : frame, channel k at [k*WIDTH +: WIDTH]
//   out_valid          : frame held on out_data
//   frame_err          : 1-cycle pulse on framing violation
//   overflow           : 1-cycle pulse when an unconsumed frame is replaced
//   state_dbg          : current FSM state
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_sof,
  input  logic               out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic               out_valid,
  output logic               frame_err,
  output logic               overflow,
  output tdm_state_e         state_dbg
);

  localparam int CW = $clog2(NCH);

  tdm_state_e             state;
  logic [NCH*WIDTH-1:0]   coll_q;
  logic [CW-1:0]          ch;
  logic                   ch_last;
  logic                   ch_clear;
  logic                   ch_load1;
  logic                   ch_en;
  logic                   wr_word;
  logic [CW-1:0]          wr_slot;
  logic                   complete;
  logic                   err;

  assign state_dbg = state;

  tdm_demux_chan_cnt #(.NCH(NCH)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ch_clear),
    .load1   (ch_load1),
    .en      (ch_en),
    .ch      (ch),
    .last    (ch_last)
  );

  // Per-word decode. An sof word always restarts at slot 0, which also
  // drops any partial frame (its stale slots are rewritten before use).
  always_comb begin
    ch_clear = 1'b0;
    ch_load1 = 1'b0;
    ch_en    = 1'b0;
    wr_word  = 1'b0;
    wr_slot  = '0;
    complete = 1'b0;
    err      = 1'b0;
    if (in_valid) begin
      case (state)
        ST_HUNT: begin
          if (in_sof) begin
            wr_word  = 1'b1;
            ch_load1 = 1'b1;
          end
        end
        ST_COLLECT: begin
          if (in_sof) begin
            wr_word  = 1'b1;
            ch_load1 = 1'b1;
            err      = (ch != '0);
          end else if (ch == '0) begin
            // Expected a frame start but got a mid-frame word: lost lock.
            err      = 1'b1;
            ch_clear = 1'b1;
          end else begin
            wr_word  = 1'b1;
            wr_slot  = ch;
            ch_en    = 1'b1;
            complete = ch_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_HUNT;
      coll_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err;
      overflow  <= complete && out_valid && !out_ready;

      case (state)
        ST_HUNT:    if (in_valid && in_sof) state <= ST_COLLECT;
        ST_COLLECT: if (err && !in_sof)     state <= ST_HUNT;
        default:    state <= ST_HUNT;
      endcase

      for (int k = 0; k < NCH; k++) begin
        if (wr_word && (wr_slot == CW'(k))) coll_q[k*WIDTH +: WIDTH] <= in_data;
      end

      // The last word bypasses the buffer so the frame publishes on its edge.
      if (complete) begin
        out_data  <= {in_data, coll_q[(NCH-1)*WIDTH-1:0]};
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;
  import tdm_demux_pkg::*;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int FW    = NCH * WIDTH;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_sof;
  logic              out_ready;
  logic [FW-1:0]     out_data;
  logic              out_valid;
  logic              frame_err;
  logic              overflow;
  tdm_state_e        state_dbg;

  int n_checks;
  int n_errors;

  // Reference model: a word queue for the partial frame and registered outputs.
  bit                m_locked;
  logic [WIDTH-1:0]  m_q[$];
  logic              m_valid;
  logic [FW-1:0]     m_data;
  logic              m_err;
  logic              m_ovf;
  logic [FW-1:0]     exp_q[$];   // frames completed, in order

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_q.delete();
    m_valid = 0;
    m_data  = '0;
    m_err   = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                            input logic r);
    logic          n_err;
    logic          done;
    logic [FW-1:0] frame;
    n_err = 0;
    done  = 0;
    frame = '0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1;
          m_q.delete();
          m_q.push_back(d);
        end
      end else if (s) begin
        n_err = (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        n_err = 1;
        m_locked = 0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == NCH) begin
          for (int k = 0; k < NCH; k++) frame[k*WIDTH +: WIDTH] = m_q[k];
          m_q.delete();
          done = 1;
        end
      end
    end
    m_ovf = done && m_valid && !r;
    m_err = n_err;
    if (done) begin
      m_valid = 1;
      m_data  = frame;
      exp_q.push_back(frame);
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".data"},  64'(out_data),  64'(m_data));
    chk({tag, ".err"},   64'(frame_err), 64'(m_err));
    chk({tag, ".ovf"},   64'(overflow),  64'(m_ovf));
    chk({tag, ".state"}, 64'(state_dbg), 64'(m_locked ? ST_COLLECT : ST_HUNT));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                      input logic r, input string tag);
    in_valid  = v;
    in_sof    = s;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    model_step(v, s, d, r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    in_valid  = 0;
    in_sof    = 0;
    in_data   = '0;
    out_ready = 0;
    reset_n   = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pos;
    logic v, s, r;
    n_checks = 0;
    n_errors = 0;
    exp_q.delete();

    // 1: basic frame
    do_reset();
    step(1, 1, 8'hA1, 1, "t1");
    step(1, 0, 8'hB2, 1, "t1");
    step(1, 0, 8'hC3, 1, "t1");
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    step(1, 0, 8'hD4, 1, "t1");
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'h0000_0000_D4C3_B2A1);
    step(0, 0, 8'h00, 1, "t1");
    chk("t1_drop", 64'(out_valid), 64'd0);

    // 2: words before sof are discarded
    do_reset();
    step(1, 0, 8'h11, 1, "t2");
    step(1, 0, 8'h22, 1, "t2");
    chk("t2_hunt", 64'(out_valid), 64'd0);
    step(1, 1, 8'h55, 1, "t2");
    step(1, 0, 8'h66, 1, "t2");
    step(1, 0, 8'h77, 1, "t2");
    step(1, 0, 8'h88, 1, "t2");
    chk("t2_data", 64'(out_data), 64'h0000_0000_8877_6655);

    // 3: early sof aborts the partial frame
    do_reset();
    step(1, 1, 8'h01, 1, "t3");
    step(1, 0, 8'h02, 1, "t3");
    step(1, 1, 8'h10, 1, "t3");
    chk("t3_err", 64'(frame_err), 64'd1);
    step(1, 0, 8'h20, 1, "t3");
    chk("t3_err_pulse", 64'(frame_err), 64'd0);
    step(1, 0, 8'h30, 1, "t3");
    step(1, 0, 8'h40, 1, "t3");
    chk("t3_data", 64'(out_data), 64'h0000_0000_4030_2010);

    // 4: backpressure, second frame overwrites the first
    do_reset();
    for (int i = 0; i < 2 * NCH; i++)
      step(1, (i % NCH) == 0, 8'(8'h50 + i), 0, "t4");
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_data", 64'(out_data), 64'h0000_0000_5756_5554);

    // 6: completion in the same cycle as acceptance
    step(1, 1, 8'hC0, 0, "t6");
    step(1, 0, 8'hC1, 0, "t6");
    step(1, 0, 8'hC2, 0, "t6");
    chk("t6_still", 64'(out_valid), 64'd1);
    step(1, 0, 8'hC3, 1, "t6");
    chk("t6_valid", 64'(out_valid), 64'd1);
    chk("t6_no_ovf", 64'(overflow), 64'd0);
    chk("t6_data", 64'(out_data), 64'h0000_0000_C3C2_C1C0);

    // 5: in_valid gaps, then async reset mid-frame
    do_reset();
    step(1, 1, 8'hA1, 1, "t5");
    step(0, 0, 8'hEE, 1, "t5");
    step(1, 0, 8'hB2, 1, "t5");
    step(0, 1, 8'hEE, 1, "t5");
    step(1, 0, 8'hC3, 1, "t5");
    step(0, 0, 8'hEE, 1, "t5");
    step(1, 0, 8'hD4, 0, "t5");
    chk("t5_data", 64'(out_data), 64'h0000_0000_D4C3_B2A1);
    step(1, 1, 8'h99, 0, "t5");
    #2;
    reset_n = 0;
    model_reset();
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_data", 64'(out_data), 64'd0);
    chk("t5_rst_state", 64'(state_dbg), 64'(ST_HUNT));
    @(posedge clk);
    #1;
    reset_n = 1;
    step(1, 0, 8'h12, 1, "t5_relock");
    chk("t5_relock_hunt", 64'(state_dbg), 64'(ST_HUNT));

    // Random: mostly well-formed frames with corrupted sof and gaps
    do_reset();
    pos = 0;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (pos == 0);
      if ($urandom_range(0, 15) == 0) s = ~s;
      r = ($urandom_range(0, 2) != 0);
      step(v, s, 8'($urandom), r, "rnd");
      if (v) pos = (s ? 1 : pos + 1) % NCH;
    end
    chk("rnd_frames_seen", 64'(exp_q.size() > 20), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
